// File: rtl/gf_divider.sv
// rtl/gf_divider.sv - sequential GF(2^m) divider (binary extended Euclid), optional GF_DIV_CONST_TIME_EN
module gf_divider #(
    parameter int m  = 16,
    parameter int k2 = 5,
    parameter int k1 = 3,
    parameter int k0 = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:m-1] dividend,
    input  logic [0:m-1] divisor,
    output logic         ready,
    output logic         done,
    output logic [0:m-1] quotient,
    output logic         div_zero
);

    localparam int CW = $clog2(4 * m + 1);

    function automatic logic [m:0] make_poly();
        logic [m:0] p;
        p     = '0;
        p[m]  = 1'b1;
        p[k2] = 1'b1;
        p[k1] = 1'b1;
        p[k0] = 1'b1;
        p[0]  = 1'b1;
        return p;
    endfunction

    localparam logic [m:0] POLY = make_poly();

`ifdef GF_DIV_CONST_TIME_EN
    localparam logic [CW-1:0] CNT_MAX = CW'(4 * m);
`endif

    // Multiply by x^-1 mod P: add P first when odd so the division by x is exact.
    function automatic logic [m-1:0] half(input logic [m-1:0] x);
        logic [m:0] t;
        t = x[0] ? ({1'b0, x} ^ POLY) : {1'b0, x};
        return t[m:1];
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [m-1:0]  a, u, v, q_r;
    logic [m:0]    b;
    logic [CW-1:0] cnt;
    logic [m-1:0]  dvd_i, dvs_i;
    logic [m-1:0]  a_n, u_n, v_n;
    logic [m:0]    b_n;
    logic          a_one, b_one;

    // Ports index coefficient i at position i; internal vectors use [m-1:0] with the same mapping.
    always_comb begin
        dvd_i    = '0;
        dvs_i    = '0;
        quotient = '0;
        for (int i = 0; i < m; i++) begin
            dvd_i[i]    = dividend[i];
            dvs_i[i]    = divisor[i];
            quotient[i] = q_r[i];
        end
    end

    assign a_one = (a == m'(1));
    assign b_one = (b == (m + 1)'(1));

    // One Euclid reduction step: halve an even operand, otherwise subtract the smaller from the larger.
    always_comb begin
        a_n = a;
        b_n = b;
        u_n = u;
        v_n = v;
        if (!a[0]) begin
            a_n = a >> 1;
            u_n = half(u);
        end else if (!b[0]) begin
            b_n = b >> 1;
            v_n = half(v);
        end else if ({1'b0, a} > b) begin
            a_n = a ^ b[m-1:0];
            u_n = u ^ v;
        end else begin
            b_n = b ^ {1'b0, a};
            v_n = v ^ u;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            q_r      <= '0;
            div_zero <= 1'b0;
            a        <= '0;
            b        <= '0;
            u        <= '0;
            v        <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dvs_i == '0) begin
                            q_r      <= '0;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            a     <= dvs_i;
                            b     <= POLY;
                            u     <= dvd_i;
                            v     <= '0;
                            cnt   <= '0;
                            ready <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
`ifdef GF_DIV_CONST_TIME_EN
                    if (cnt == CNT_MAX) begin
                        q_r      <= a_one ? u : v;
                        div_zero <= 1'b0;
                        done     <= 1'b1;
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (!(a_one || b_one)) begin
                            a <= a_n;
                            b <= b_n;
                            u <= u_n;
                            v <= v_n;
                        end
                    end
`else
                    if (a_one || b_one) begin
                        q_r      <= a_one ? u : v;
                        div_zero <= 1'b0;
                        done     <= 1'b1;
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        a   <= a_n;
                        b   <= b_n;
                        u   <= u_n;
                        v   <= v_n;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_divider.sv
// tb/tb_gf_divider.sv - scoreboard bench for gf_divider
module tb_gf_divider;

    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [0:M-1] dividend = '0;
    logic [0:M-1] divisor = '0;
    logic         ready, done, div_zero;
    logic [0:M-1] quotient;

    gf_divider dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .ready(ready), .done(done), .quotient(quotient), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] q;
        logic        z;
        int          due;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [0:15] to_port(input logic [15:0] x);
        logic [0:15] r;
        for (int i = 0; i < 16; i++) r[i] = x[i];
        return r;
    endfunction

    function automatic logic [15:0] from_port(input logic [0:15] x);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = x[i];
        return r;
    endfunction

    function automatic logic [15:0] gf_mul(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            r = (r << 1) ^ (r[15] ? 16'h002D : 16'h0000);
            if (y[i]) r = r ^ x;
        end
        return r;
    endfunction

    function automatic int lat(input int n);
`ifdef GF_DIV_CONST_TIME_EN
        return 64;
`else
        return n;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("quotient", 32'(from_port(quotient)), 32'(e.q));
                check("div_zero", 32'(div_zero), 32'(e.z));
                if (e.due >= 0) check("latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic issue(input logic [15:0] dvd, input logic [15:0] dvs,
                         input logic [15:0] exp_q, input logic exp_z, input int n);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1");
        end
        start    = 1'b1;
        dividend = to_port(dvd);
        divisor  = to_port(dvs);
        @(posedge clk);
        #1;
        start = 1'b0;
        e.q   = exp_q;
        e.z   = exp_z;
        e.due = exp_z ? cyc : ((n < 0) ? -1 : cyc + 1 + n);
        sb.push_back(e);
    endtask

    task automatic poke_busy();
        @(negedge clk);
        if (!ready) begin
            start    = 1'b1;
            dividend = to_port(16'hBEEF);
            divisor  = to_port(16'h0001);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] ra, rc;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", 32'(from_port(quotient)), 32'd0);
        check("reset_div_zero", 32'(div_zero), 32'd0);

        issue(16'hA455, 16'h0001, 16'hA455, 1'b0, lat(0));
        issue(16'h002D, 16'h8000, 16'h0002, 1'b0, lat(15));
        poke_busy();
        issue(16'h002D, 16'h0002, 16'h8000, 1'b0, lat(1));
        issue(16'hA455, 16'hA455, 16'h0001, 1'b0, lat(-1));
        issue(16'h0000, 16'hA455, 16'h0000, 1'b0, lat(-1));
        issue(16'h1234, 16'h0000, 16'h0000, 1'b1, 0);
        issue(16'h0003, 16'h0001, 16'h0003, 1'b0, lat(0));
        drain();

        // Abort a division in flight with a one-cycle reset.
        issue(16'h002D, 16'h8000, 16'h0002, 1'b0, lat(15));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(from_port(quotient)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h002D, 16'h0002, 16'h8000, 1'b0, lat(1));
        drain();

        // Round trip: (A*c)/c must give back A.
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rc = 16'($urandom);
            if (rc == 16'h0000) rc = 16'h0001;
            issue(gf_mul(ra, rc), rc, ra, 1'b0, lat(-1));
            if (i % 37 == 0) poke_busy();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
